fp_operand_fetch: RTL and testbench
===================================

# fp_operand_fetch

Two-stage operand-fetch pipeline between the FP issue queue and the FP execution units. Accepts one issued FP uop per cycle with up to three source register tags and drives three read ports of the FP register file. Bypasses results being written to the register file's two write ports in the same cycle, then delivers a registered uop with resolved operands to the FPU through a valid/ready handshake.

## Interface
- WIDTH, 32, operand data width; equals register-file WIDTH
- TAG_W, 6, register tag width; 64 FP registers
- OP_W, 8, opaque uop payload width (opcode, rounding mode, ROB id); passed through unchanged
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- flush  in  1  synchronous pipeline kill (branch mispredict or exception)
- in_valid  in  1  issue uop valid
- in_ready  out  1  stage R can accept
- in_op  in  OP_W  uop payload
- in_rd  in  TAG_W  destination tag
- in_rs1, in_rs2, in_rs3  in  TAG_W  source tags
- in_use3  in  1  rs3 is used (FMA class)
- rf_raddr0, rf_raddr1, rf_raddr2  out  TAG_W  to register-file read ports 0..2
- rf_rdata0, rf_rdata1, rf_rdata2  in  WIDTH  combinational read data
- wb_en0, wb_en1  in  1  register-file write enables (same signals as RF wen0/wen1)
- wb_tag0, wb_tag1  in  TAG_W  register-file write addresses
- wb_data0, wb_data1  in  WIDTH  register-file write data
- out_valid  out  1  operand bundle valid
- out_ready  in  1  FPU accepts
- out_op  out  OP_W, out_rd  out  TAG_W  payload and destination
- out_a, out_b, out_c  out  WIDTH  operands for rs1, rs2, rs3

## Operation
- Stage R register holds r_valid, op, rd, rs1..3, use3. rf_raddr0/1/2 = R.rs1/rs2/rs3, driven from registers only (no combinational path from in_*).
- Operand resolution in stage R, per source s: if wb_en1 && wb_tag1 == tag_s, take wb_data1; else if wb_en0 && wb_tag0 == tag_s, take wb_data0; else take rf_rdata_s. Port 1 wins over port 0 on equal tags, matching register-file write ordering.
- For rs3 with use3 = 0, the resolved value is forced to 0.
- Stage O register holds out_valid, out_op, out_rd, out_a/b/c.
- o_free = !out_valid || out_ready.
- r_adv = r_valid && o_free.
- in_ready = !r_valid || r_adv. in_ready is combinational from out_ready; this is required for full throughput.
- On each edge (rst_n = 1, flush = 0):
  - If o_free, stage O loads stage R's resolved bundle and out_valid <= r_valid.
  - If in_ready, stage R loads in_* and r_valid <= in_valid.
- A uop stalled in R re-reads and re-resolves every cycle. The value captured is the one resolved in the cycle O accepts, so no stale operands are ever captured.
- flush: next edge r_valid <= 0 and out_valid <= 0; the in_* uop presented that cycle is dropped. flush has priority over in_valid and out_ready. The FPU must not treat a bundle as accepted in a flush cycle.
- rst_n = 0 has priority over flush.

## Timing
- Latency: uop accepted at edge E0 appears on out_* after edge E1 (out_valid high in the cycle after E1), given no stall. Throughput is 1 uop/cycle.
- A write on wb_* in any cycle the uop sits in R is reflected in its operands. A write in the cycle the uop enters R is visible through the register file one edge later, which is in time for R.
- Writes occurring while the uop sits in O are not tracked; issue logic guarantees no producer writes a tag after its consumer leaves R.
- Reset values: r_valid = 0, out_valid = 0, in_ready = 1, rf_raddr0..2 = 0, out_op = 0, out_rd = 0, out_a/b/c = 0.
- Payload and operand registers in O hold their values while out_valid && !out_ready. Values are don't-care when out_valid = 0 but must not glitch while out_valid = 1.

## Test plan
- Back-to-back: 4 uops on consecutive cycles, out_ready = 1, RF holds f1 = 0x3F800000 and f2 = 0x40000000 → 4 bundles on consecutive cycles, each 2 cycles after issue, with out_a = 0x3F800000 and out_b = 0x40000000.
- Bypass priority: uop rs1 = 5 in R while wb_en0 (tag 5, 0x11111111) and wb_en1 (tag 5, 0x22222222) are both active → out_a = 0x22222222. Repeat with only port 0 active → out_a = 0x11111111.
- Stall: out_ready = 0 for 3 cycles with a uop in O and one in R; write tag rs2 of the R uop (0xDEADBEEF) during the stall → O payload stable, in_ready = 0. After release, the second bundle has out_b = 0xDEADBEEF.
- use3 = 0 with rs3 = 7 and RF f7 = 0xFFFFFFFF → out_c = 0. With use3 = 1 → out_c = 0xFFFFFFFF.
- Flush with both stages valid and in_valid = 1 → out_valid = 0 and r_valid = 0 next cycle. No flushed uop ever appears; the next issued uop flows normally.
- rst_n low for 1 cycle mid-stream → all outputs at reset values the following cycle and in_ready = 1.

Source files
------------

// File: rtl/fp_operand_fetch.sv
// Two-stage FP operand fetch: stage R reads the register file and bypasses
// same-cycle write-backs; stage O presents the resolved bundle to the FPU.
module fp_operand_fetch #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 6,
  parameter int unsigned OP_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [TAG_W-1:0] in_rd,
  input  logic [TAG_W-1:0] in_rs1,
  input  logic [TAG_W-1:0] in_rs2,
  input  logic [TAG_W-1:0] in_rs3,
  input  logic             in_use3,
  output logic [TAG_W-1:0] rf_raddr0,
  output logic [TAG_W-1:0] rf_raddr1,
  output logic [TAG_W-1:0] rf_raddr2,
  input  logic [WIDTH-1:0] rf_rdata0,
  input  logic [WIDTH-1:0] rf_rdata1,
  input  logic [WIDTH-1:0] rf_rdata2,
  input  logic             wb_en0,
  input  logic             wb_en1,
  input  logic [TAG_W-1:0] wb_tag0,
  input  logic [TAG_W-1:0] wb_tag1,
  input  logic [WIDTH-1:0] wb_data0,
  input  logic [WIDTH-1:0] wb_data1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OP_W-1:0]  out_op,
  output logic [TAG_W-1:0] out_rd,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c
);

  logic             r_valid_q, r_valid_d;
  logic [OP_W-1:0]  r_op_q, r_op_d;
  logic [TAG_W-1:0] r_rd_q, r_rd_d;
  logic [TAG_W-1:0] r_rs1_q, r_rs1_d;
  logic [TAG_W-1:0] r_rs2_q, r_rs2_d;
  logic [TAG_W-1:0] r_rs3_q, r_rs3_d;
  logic             r_use3_q, r_use3_d;

  logic             out_valid_q, out_valid_d;
  logic [OP_W-1:0]  out_op_q, out_op_d;
  logic [TAG_W-1:0] out_rd_q, out_rd_d;
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;
  logic [WIDTH-1:0] out_c_q, out_c_d;

  logic             o_free;
  logic             r_adv;
  logic [WIDTH-1:0] res_a, res_b, res_c;

  // Port 1 is checked first so it wins on equal tags, as in the register file.
  function automatic logic [WIDTH-1:0] resolve(
    input logic [TAG_W-1:0] tag,
    input logic [WIDTH-1:0] rdata,
    input logic             en0,
    input logic [TAG_W-1:0] tag0,
    input logic [WIDTH-1:0] data0,
    input logic             en1,
    input logic [TAG_W-1:0] tag1,
    input logic [WIDTH-1:0] data1
  );
    logic [WIDTH-1:0] v;
    if (en1 && (tag1 == tag))      v = data1;
    else if (en0 && (tag0 == tag)) v = data0;
    else                           v = rdata;
    return v;
  endfunction

  assign rf_raddr0 = r_rs1_q;
  assign rf_raddr1 = r_rs2_q;
  assign rf_raddr2 = r_rs3_q;

  assign out_valid = out_valid_q;
  assign out_op    = out_op_q;
  assign out_rd    = out_rd_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_c     = out_c_q;

  always_comb begin
    o_free   = !out_valid_q || out_ready;
    r_adv    = r_valid_q && o_free;
    in_ready = !r_valid_q || r_adv;

    res_a = resolve(r_rs1_q, rf_rdata0, wb_en0, wb_tag0, wb_data0, wb_en1, wb_tag1, wb_data1);
    res_b = resolve(r_rs2_q, rf_rdata1, wb_en0, wb_tag0, wb_data0, wb_en1, wb_tag1, wb_data1);
    res_c = r_use3_q
          ? resolve(r_rs3_q, rf_rdata2, wb_en0, wb_tag0, wb_data0, wb_en1, wb_tag1, wb_data1)
          : '0;
  end

  always_comb begin
    r_valid_d   = r_valid_q;
    r_op_d      = r_op_q;
    r_rd_d      = r_rd_q;
    r_rs1_d     = r_rs1_q;
    r_rs2_d     = r_rs2_q;
    r_rs3_d     = r_rs3_q;
    r_use3_d    = r_use3_q;
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_rd_d    = out_rd_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_c_d     = out_c_q;

    if (flush) begin
      r_valid_d   = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (o_free) begin
        out_valid_d = r_valid_q;
        out_op_d    = r_op_q;
        out_rd_d    = r_rd_q;
        out_a_d     = res_a;
        out_b_d     = res_b;
        out_c_d     = res_c;
      end
      if (in_ready) begin
        r_valid_d = in_valid;
        r_op_d    = in_op;
        r_rd_d    = in_rd;
        r_rs1_d   = in_rs1;
        r_rs2_d   = in_rs2;
        r_rs3_d   = in_rs3;
        r_use3_d  = in_use3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid_q   <= 1'b0;
      r_op_q      <= '0;
      r_rd_q      <= '0;
      r_rs1_q     <= '0;
      r_rs2_q     <= '0;
      r_rs3_q     <= '0;
      r_use3_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_rd_q    <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_c_q     <= '0;
    end else begin
      r_valid_q   <= r_valid_d;
      r_op_q      <= r_op_d;
      r_rd_q      <= r_rd_d;
      r_rs1_q     <= r_rs1_d;
      r_rs2_q     <= r_rs2_d;
      r_rs3_q     <= r_rs3_d;
      r_use3_q    <= r_use3_d;
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_rd_q    <= out_rd_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_c_q     <= out_c_d;
    end
  end

endmodule

// File: tb/tb_fp_operand_fetch.sv
// Bench for fp_operand_fetch: directed scenarios then random traffic, checked
// against a queue model that snapshots operands from the RF image when a uop leaves R.
module tb_fp_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, in_use3;
  logic [7:0]  in_op, out_op;
  logic [5:0]  in_rd, in_rs1, in_rs2, in_rs3, out_rd;
  logic [5:0]  rf_raddr0, rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata0, rf_rdata1, rf_rdata2;
  logic        wb_en0, wb_en1;
  logic [5:0]  wb_tag0, wb_tag1;
  logic [31:0] wb_data0, wb_data1;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b, out_c;

  logic [31:0] rf_mem [64];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  op;
    logic [5:0]  rd, rs1, rs2, rs3;
    logic        use3;
    logic [31:0] a, b, c;
  } uop_t;

  uop_t pipe[$];
  int   n_in_o = 0;
  bit   exp_zero = 0;

  always #5 clk = ~clk;

  fp_operand_fetch #(.WIDTH(32), .TAG_W(6), .OP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3), .in_use3(in_use3),
    .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_en0(wb_en0), .wb_en1(wb_en1), .wb_tag0(wb_tag0), .wb_tag1(wb_tag1),
    .wb_data0(wb_data0), .wb_data1(wb_data1),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_rd(out_rd),
    .out_a(out_a), .out_b(out_b), .out_c(out_c)
  );

  // Register file image: later write wins, so port 1 overrides port 0.
  assign rf_rdata0 = rf_mem[rf_raddr0];
  assign rf_rdata1 = rf_mem[rf_raddr1];
  assign rf_rdata2 = rf_mem[rf_raddr2];
  always @(posedge clk) begin
    if (wb_en0) rf_mem[wb_tag0] <= wb_data0;
    if (wb_en1) rf_mem[wb_tag1] <= wb_data1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Register contents once this cycle's writes have landed.
  function automatic logic [31:0] rf_after(input logic [5:0] tag);
    logic [31:0] v;
    v = rf_mem[tag];
    if (wb_en0 && wb_tag0 == tag) v = wb_data0;
    if (wb_en1 && wb_tag1 == tag) v = wb_data1;
    return v;
  endfunction

  task automatic model_edge();
    bit   o_free, r_occ, take;
    uop_t u;
    if (!rst_n) begin
      pipe.delete();
      n_in_o   = 0;
      exp_zero = 1;
    end else begin
      exp_zero = 0;
      if (flush) begin
        pipe.delete();
        n_in_o = 0;
      end else begin
        o_free = (n_in_o == 0) || out_ready;
        r_occ  = pipe.size() > n_in_o;
        take   = !r_occ || o_free;
        if (n_in_o == 1 && out_ready) begin
          pipe.delete(0);
          n_in_o = 0;
        end
        if (r_occ && o_free) begin
          u   = pipe[0];
          u.a = rf_after(u.rs1);
          u.b = rf_after(u.rs2);
          u.c = u.use3 ? rf_after(u.rs3) : 32'h0;
          pipe[0] = u;
          n_in_o  = 1;
        end
        if (take && in_valid) begin
          u.op = in_op; u.rd = in_rd; u.rs1 = in_rs1; u.rs2 = in_rs2;
          u.rs3 = in_rs3; u.use3 = in_use3;
          u.a = 'x; u.b = 'x; u.c = 'x;
          pipe.push_back(u);
        end
      end
    end
  endtask

  task automatic check_all();
    bit r_occ;
    r_occ = pipe.size() > n_in_o;
    chk("out_valid", 32'(out_valid), 32'(n_in_o == 1));
    chk("in_ready", 32'(in_ready), 32'(!r_occ || n_in_o == 0 || out_ready));
    if (n_in_o == 1) begin
      chk("out_op", 32'(out_op), 32'(pipe[0].op));
      chk("out_rd", 32'(out_rd), 32'(pipe[0].rd));
      chk("out_a", out_a, pipe[0].a);
      chk("out_b", out_b, pipe[0].b);
      chk("out_c", out_c, pipe[0].c);
    end
    if (r_occ) begin
      chk("rf_raddr0", 32'(rf_raddr0), 32'(pipe[n_in_o].rs1));
      chk("rf_raddr1", 32'(rf_raddr1), 32'(pipe[n_in_o].rs2));
      chk("rf_raddr2", 32'(rf_raddr2), 32'(pipe[n_in_o].rs3));
    end
    if (exp_zero) begin
      chk("rst_out_op", 32'(out_op), 32'h0);
      chk("rst_out_rd", 32'(out_rd), 32'h0);
      chk("rst_out_a", out_a, 32'h0);
      chk("rst_out_b", out_b, 32'h0);
      chk("rst_out_c", out_c, 32'h0);
      chk("rst_raddr0", 32'(rf_raddr0), 32'h0);
      chk("rst_raddr1", 32'(rf_raddr1), 32'h0);
      chk("rst_raddr2", 32'(rf_raddr2), 32'h0);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic issue(input bit v, input logic [5:0] s1, input logic [5:0] s2,
                       input logic [5:0] s3, input bit u3);
    in_valid = v;
    in_op    = 8'($urandom);
    in_rd    = 6'($urandom);
    in_rs1   = s1;
    in_rs2   = s2;
    in_rs3   = s3;
    in_use3  = u3;
  endtask

  task automatic wb(input bit e0, input logic [5:0] t0, input logic [31:0] d0,
                    input bit e1, input logic [5:0] t1, input logic [31:0] d1);
    wb_en0 = e0; wb_tag0 = t0; wb_data0 = d0;
    wb_en1 = e1; wb_tag1 = t1; wb_data1 = d1;
  endtask

  function automatic logic [31:0] preload_val(input logic [5:0] tag);
    case (tag)
      6'd1:    return 32'h3F800000;
      6'd2:    return 32'h40000000;
      6'd7:    return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    issue(0, 0, 0, 0, 0);
    wb(0, 0, 0, 0, 0, 0);

    // Reset, while loading the register file through both write ports.
    for (int i = 0; i < 32; i++) begin
      wb(1, 6'(2 * i), preload_val(6'(2 * i)), 1, 6'(2 * i + 1), preload_val(6'(2 * i + 1)));
      step();
    end
    wb(0, 0, 0, 0, 0, 0);
    step();
    chk("reset_in_ready", 32'(in_ready), 32'h1);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    rst_n = 1'b1;
    step();

    // Back-to-back issue, one bundle per cycle two cycles after issue.
    for (int i = 0; i < 4; i++) begin
      issue(1, 6'd1, 6'd2, 6'd3, 0);
      step();
      if (i > 0) begin
        chk("b2b_valid", 32'(out_valid), 32'h1);
        chk("b2b_a", out_a, 32'h3F800000);
        chk("b2b_b", out_b, 32'h40000000);
      end
    end
    issue(0, 0, 0, 0, 0);
    step();
    chk("b2b_last_a", out_a, 32'h3F800000);
    chk("b2b_last_b", out_b, 32'h40000000);
    step();

    // Bypass priority: both ports on tag 5, then port 0 alone.
    issue(1, 6'd5, 6'd2, 6'd3, 0);
    step();
    issue(0, 0, 0, 0, 0);
    wb(1, 6'd5, 32'h11111111, 1, 6'd5, 32'h22222222);
    step();
    chk("byp_p1_wins", out_a, 32'h22222222);
    wb(0, 0, 0, 0, 0, 0);
    issue(1, 6'd5, 6'd2, 6'd3, 0);
    step();
    issue(0, 0, 0, 0, 0);
    wb(1, 6'd5, 32'h11111111, 0, 6'd5, 32'h22222222);
    step();
    chk("byp_p0_only", out_a, 32'h11111111);
    wb(0, 0, 0, 0, 0, 0);
    step();

    // Stall with a write to the R uop's rs2 during the stall.
    issue(1, 6'd1, 6'd3, 6'd4, 0);
    step();
    issue(1, 6'd1, 6'd9, 6'd4, 0);
    step();
    issue(0, 0, 0, 0, 0);
    out_ready = 1'b0;
    wb(1, 6'd9, 32'hDEADBEEF, 0, 0, 0);
    step();
    chk("stall_in_ready", 32'(in_ready), 32'h0);
    wb(0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("stall_in_ready2", 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    step();
    chk("stall_out_b", out_b, 32'hDEADBEEF);
    step();

    // use3 gating of the third operand.
    issue(1, 6'd1, 6'd2, 6'd7, 0);
    step();
    issue(1, 6'd1, 6'd2, 6'd7, 1);
    step();
    chk("use3_off_c", out_c, 32'h0);
    issue(0, 0, 0, 0, 0);
    step();
    chk("use3_on_c", out_c, 32'hFFFFFFFF);
    step();

    // Flush with both stages full and a new uop offered.
    out_ready = 1'b0;
    issue(1, 6'd1, 6'd2, 6'd3, 0);
    step();
    issue(1, 6'd2, 6'd1, 6'd3, 0);
    step();
    issue(1, 6'd3, 6'd3, 6'd3, 1);
    flush = 1'b1;
    step();
    chk("flush_out_valid", 32'(out_valid), 32'h0);
    chk("flush_in_ready", 32'(in_ready), 32'h1);
    flush = 1'b0;
    out_ready = 1'b1;
    issue(1, 6'd2, 6'd1, 6'd7, 1);
    step();
    issue(0, 0, 0, 0, 0);
    step();
    chk("post_flush_a", out_a, 32'h40000000);
    step();

    // Reset mid-stream.
    issue(1, 6'd1, 6'd2, 6'd3, 0);
    step();
    step();
    rst_n = 1'b0;
    step();
    chk("midrst_in_ready", 32'(in_ready), 32'h1);
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    rst_n = 1'b1;
    issue(0, 0, 0, 0, 0);
    step();

    // Random traffic over a small tag window so bypass hits are frequent.
    for (int i = 0; i < 400; i++) begin
      issue(($urandom_range(0, 3) != 0), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
            6'($urandom_range(0, 7)), 1'($urandom));
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 29) == 0);
      wb(1'($urandom), 6'($urandom_range(0, 7)), $urandom,
         1'($urandom), 6'($urandom_range(0, 7)), $urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
